wb_queue: RTL
=============

// Module: wb_queue
// PURPOSE
//  Writeback queue sitting directly upstream of the 16x16 register file write port.
//  Buffers ALU/memory results (dst, data) in a small FIFO.
//  Drains the head into the register file only on cycles where the read side is not
//  using it; the register file does either a read or a write per clk, and read wins.
//  Reports read-after-write hazards for the three register-file read sources against
//  pending entries.
// PARAMETERS
//  DEPTH  4   queue entries, power of 2, 2..16
//  DW     16  data width, matches register file word
//  AW     4   register address width (16 registers)
// PORTS
//  clk         in   1     clock; all state updates on posedge
//  rst_n       in   1     asynchronous active-low reset
//  flush       in   1     synchronous clear of all pending entries
//  in_valid    in   1     producer offers a result
//  in_ready    out  1     queue accepts the result this cycle
//  in_dst      in   AW    destination register
//  in_data     in   DW    result value
//  regread     in   1     decode is reading the register file this cycle
//  regwrite    out  1     write strobe to the register file
//  regwritedst out  AW    write address (head entry)
//  writedata   out  DW    write data (head entry)
//  src1/2/3    in   AW    register file read sources for this cycle
//  srcv1/2/3   in   1     the matching source is actually used
//  stall       out  1     hazard: decode must not consume read data this cycle
//  count       out  log2(DEPTH)+1  entries pending
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, rd/wr pointers=0, in_ready=1, regwrite=0, stall=0,
//    regwritedst=0, writedata=0. Entry contents are don't-care.
//  - in_ready = (count != DEPTH). This holds even if a pop occurs the same cycle;
//    no push-while-full.
//  - Push: in_valid & in_ready at posedge. Writes entry[wr_ptr] and increments wr_ptr
//    (wraps modulo DEPTH).
//  - regwrite = (count != 0) & !regread & !flush, combinational.
//    regwritedst/writedata = entry[rd_ptr] when count != 0, else 0.
//    They change only at posedge, so they are stable at the register file negedge sample.
//  - Pop: at the posedge following a cycle with regwrite=1, rd_ptr increments (wraps).
//    Latency from accepted push to register-file write: min 1 clk (next cycle's negedge).
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//  - Ordering: strict FIFO. Two pending writes to the same dst retire in order;
//    the last one wins.
//  - flush: count=0 and rd_ptr=wr_ptr at posedge; any push that cycle is dropped.
//    regwrite is forced 0 during flush.
//  - Hazard: hitN = srcvN & (any valid entry with dst==srcN).
//    Valid entry = within count slots starting at rd_ptr.
//  - An entry retiring this cycle still counts as pending. No hit against an in_* push
//    of the same cycle.
//  - stall is combinational; it carries no state and has no reset dependence beyond count=0.
//  - Reset mid-drain: pending entries are lost; regwrite drops immediately (async).
// CONFIGURATION
//  WBQ_BYPASS_EN defined:
//   - adds outputs fwd_hit1/2/3 (1) and fwd_data1/2/3 (DW).
//   - fwd_dataN = youngest matching pending entry's data.
//   - stall is tied 0; decode muxes fwd_dataN over register-file data when fwd_hitN.
//  WBQ_BYPASS_EN undefined:
//   - no forwarding ports.
//   - stall = hit1|hit2|hit3.
// TESTING
//  1. Reset, then push (dst=3, data=16'hBEEF) with regread=0
//     -> next cycle regwrite=1, regwritedst=3, writedata=BEEF; count returns 0 after that posedge.
//  2. Push 4 entries (r1..r4 = 0x0011..0x0044) with regread=1
//     -> in_ready=0 at count=4, 5th push not accepted.
//     Release regread -> four writes in order r1..r4 on consecutive cycles.
//  3. Push r5=0xAAAA then r5=0x5555, regread=1, src1=5, srcv1=1
//     -> stall=1 (no bypass), or fwd_hit1=1 with fwd_data1=0x5555 (bypass).
//  4. Queue full with regread=0 and in_valid=1
//     -> pop occurs, push rejected, count 4->3; next cycle push accepted, count stays 3.
//  5. Three entries pending, assert flush with in_valid=1
//     -> count=0, regwrite=0, stall=0 next cycle; the flushed push never appears.
//  6. Deassert rst_n between clock edges with entries pending
//     -> regwrite, count and stall go 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: writeback FIFO in front of the single-port register file write side.
// Results are buffered as (dst, data) and drained one per cycle whenever decode is
// not reading the register file. Pending entries are compared against the three
// read sources to flag read-after-write hazards.
// Optional feature macro: WBQ_BYPASS_EN -- when defined, the queue forwards the
// youngest matching pending data on fwd_hitN/fwd_dataN and stall is tied low.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_dst,
    input  logic [DW-1:0]            in_data,
    input  logic                     regread,
    output logic                     regwrite,
    output logic [AW-1:0]            regwritedst,
    output logic [DW-1:0]            writedata,
    input  logic [AW-1:0]            src1,
    input  logic [AW-1:0]            src2,
    input  logic [AW-1:0]            src3,
    input  logic                     srcv1,
    input  logic                     srcv2,
    input  logic                     srcv3,
`ifdef WBQ_BYPASS_EN
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic                     fwd_hit3,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [DW-1:0]            fwd_data3,
`endif
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Control state
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    // Entry storage; contents are don't-care after reset, so no reset here
    logic [AW-1:0] dst_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic push;
    logic pop;

    // Read sources gathered into arrays so the hazard scan can loop over them
    logic [AW-1:0] src_a  [3];
    logic          srcv_a [3];
    logic [2:0]    hit;
    logic [PW-1:0] slot;
`ifdef WBQ_BYPASS_EN
    logic [DW-1:0] fwd_d  [3];
`endif

    assign src_a[0]  = src1;
    assign src_a[1]  = src2;
    assign src_a[2]  = src3;
    assign srcv_a[0] = srcv1;
    assign srcv_a[1] = srcv2;
    assign srcv_a[2] = srcv3;

    // in_ready ignores a same-cycle pop: a full queue never takes a push
    assign in_ready = (count_q != FULL);
    assign push     = in_valid & in_ready & ~flush;

    // Read side has priority over the write port; flush suppresses the write
    assign regwrite    = (count_q != '0) & ~regread & ~flush;
    assign pop         = regwrite;
    assign regwritedst = (count_q != '0) ? dst_q[rd_ptr_q]  : '0;
    assign writedata   = (count_q != '0) ? data_q[rd_ptr_q] : '0;
    assign count       = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry write on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            dst_q[wr_ptr_q]  <= in_dst;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    // Hazard scan oldest to youngest, so the last match is the youngest entry;
    // the retiring head is still pending and an incoming push is not yet visible
    always_comb begin
        hit  = '0;
        slot = '0;
`ifdef WBQ_BYPASS_EN
        for (int j = 0; j < 3; j++) fwd_d[j] = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                for (int j = 0; j < 3; j++) begin
                    if (srcv_a[j] && (dst_q[slot] == src_a[j])) begin
                        hit[j] = 1'b1;
`ifdef WBQ_BYPASS_EN
                        fwd_d[j] = data_q[slot];
`endif
                    end
                end
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    assign fwd_hit1  = hit[0];
    assign fwd_hit2  = hit[1];
    assign fwd_hit3  = hit[2];
    assign fwd_data1 = fwd_d[0];
    assign fwd_data2 = fwd_d[1];
    assign fwd_data3 = fwd_d[2];
    assign stall     = 1'b0;
`else
    assign stall     = |hit;
`endif

endmodule
